// File: rtl/periph_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : periph_timer_pkg
//  Description : Shared widths, register indices and CTRL layout for the timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package periph_timer_pkg;

    localparam int c_periph_data_width = 32;
    localparam int c_periph_addr_width = 6;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_COUNT    = 3'd3,
        REG_STATUS   = 3'd4
    } timer_reg_e;

    // Packed so that bit 0 is EN, bit 1 AUTORELOAD, bit 2 IRQEN.
    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } timer_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/periph_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : periph_timer_if
//  Description : Strobe/ready peripheral bus from the ioslot decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface periph_timer_if
    import periph_timer_pkg::*;
#(
    parameter int ADDR_WIDTH = c_periph_addr_width
);
    logic [ADDR_WIDTH-1:0] io_addr;
    logic                  io_read;
    logic                  io_write;
    logic                  io_ready;

    modport master (output io_addr, output io_read, output io_write, input io_ready);
    modport slave  (input io_addr, input io_read, input io_write, output io_ready);
endinterface
`default_nettype wire

// File: rtl/periph_timer_bus.sv
`default_nettype none
// ============================================================================
//  Module      : periph_timer_bus
//  Description : Generic one-wait-state slave: strobe->ack, read latch, tri-state.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_timer_bus
    import periph_timer_pkg::*;
#(
    parameter int DATA_WIDTH = c_periph_data_width,
    parameter int ADDR_WIDTH = c_periph_addr_width
) (
    input  logic                  clk,
    input  logic                  rst,
    periph_timer_if.slave         bus,
    inout  wire  [DATA_WIDTH-1:0] io_data,
    output logic                  wr_stb,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rd_value
);

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_take;
    logic                  w_drive;

    // An access is taken only while not already acknowledging, so a held
    // strobe yields one access per ready pulse.
    assign w_take  = (bus.io_read | bus.io_write) & ~r_ack;
    assign w_drive = bus.io_read & r_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_take;
            if (w_take && !bus.io_write) begin
                r_rdata <= rd_value;
            end
        end
    end

    assign bus.io_ready = r_ack;
    assign io_data      = w_drive ? r_rdata : {DATA_WIDTH{1'bz}};
    assign wr_stb       = w_take & bus.io_write;
    assign addr         = bus.io_addr;
    assign wdata        = io_data;

endmodule
`default_nettype wire

// File: rtl/periph_timer.sv
`default_nettype none
// ============================================================================
//  Module      : periph_timer
//  Description : Prescaled compare timer with CTRL/PRESCALE/COMPARE/COUNT/STATUS.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter int PERIPH_DATA_WIDTH = c_periph_data_width,
    parameter int PERIPH_ADDR_WIDTH = c_periph_addr_width
) (
    input  logic                         clk,
    input  logic                         rst,
    periph_timer_if.slave                bus,
    inout  wire  [PERIPH_DATA_WIDTH-1:0] io_data,
    output logic                         irq
);

    localparam int DW = PERIPH_DATA_WIDTH;
    localparam int AW = PERIPH_ADDR_WIDTH;

    logic          w_wr_stb;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rd_value;

    timer_ctrl_t   r_ctrl;
    logic [DW-1:0] r_prescale;
    logic [DW-1:0] r_compare;
    logic [DW-1:0] r_count;
    logic [DW-1:0] r_presc_cnt;
    logic          r_match;

    logic w_tick;
    logic w_hit;
    logic w_wr_ctrl;
    logic w_wr_prescale;
    logic w_wr_compare;
    logic w_wr_count;
    logic w_wr_status;

    periph_timer_bus #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_bus (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .io_data  (io_data),
        .wr_stb   (w_wr_stb),
        .addr     (w_addr),
        .wdata    (w_wdata),
        .rd_value (w_rd_value)
    );

    assign w_wr_ctrl     = w_wr_stb && (w_addr == AW'(REG_CTRL));
    assign w_wr_prescale = w_wr_stb && (w_addr == AW'(REG_PRESCALE));
    assign w_wr_compare  = w_wr_stb && (w_addr == AW'(REG_COMPARE));
    assign w_wr_count    = w_wr_stb && (w_addr == AW'(REG_COUNT));
    assign w_wr_status   = w_wr_stb && (w_addr == AW'(REG_STATUS));

    // Equality compare means a PRESCALE lowered below presc_cnt runs to wrap.
    assign w_tick = r_ctrl.en && (r_presc_cnt == r_prescale);
    assign w_hit  = w_tick && (r_count == r_compare);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_prescale  <= '0;
            r_compare   <= '0;
            r_count     <= '0;
            r_presc_cnt <= '0;
            r_match     <= 1'b0;
        end else begin
            r_presc_cnt <= (!r_ctrl.en || w_tick) ? '0 : r_presc_cnt + DW'(1);

            if (w_wr_prescale) r_prescale <= w_wdata;
            if (w_wr_compare)  r_compare  <= w_wdata;

            // CPU writes to CTRL and COUNT override any same-edge tick effect.
            if (w_wr_ctrl) begin
                r_ctrl <= timer_ctrl_t'(w_wdata[$bits(timer_ctrl_t)-1:0]);
            end else if (w_hit && !r_ctrl.autoreload) begin
                r_ctrl.en <= 1'b0;
            end

            if (w_wr_count) begin
                r_count <= w_wdata;
            end else if (w_hit) begin
                if (r_ctrl.autoreload) r_count <= '0;
            end else if (w_tick) begin
                r_count <= r_count + DW'(1);
            end

            // A new match beats a coincident write-1-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status && w_wdata[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_value = '0;
        case (w_addr)
            AW'(REG_CTRL):     w_rd_value = DW'(r_ctrl);
            AW'(REG_PRESCALE): w_rd_value = r_prescale;
            AW'(REG_COMPARE):  w_rd_value = r_compare;
            AW'(REG_COUNT):    w_rd_value = r_count;
            AW'(REG_STATUS):   w_rd_value = DW'(r_match);
            default:           w_rd_value = '0;
        endcase
    end

    assign irq = r_match & r_ctrl.irqen;

endmodule
`default_nettype wire

// File: tb/tb_periph_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_periph_timer
//  Description : Directed self-checking bench for periph_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_timer;

    localparam logic [5:0] A_CTRL     = 6'd0;
    localparam logic [5:0] A_PRESCALE = 6'd1;
    localparam logic [5:0] A_COMPARE  = 6'd2;
    localparam logic [5:0] A_COUNT    = 6'd3;
    localparam logic [5:0] A_STATUS   = 6'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    wire  [31:0] io_data;
    logic [31:0] tb_wdata;
    logic        tb_drive;
    int          n_total = 0;
    int          n_bad   = 0;

    periph_timer_if bus_if ();

    periph_timer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .io_data (io_data),
        .irq     (irq)
    );

    assign io_data = tb_drive ? tb_wdata : 32'bz;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    // Starts on the next falling edge; the access commits on the following
    // rising edge and the task returns at the falling edge where ready is seen.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus_if.io_addr  = a;
        bus_if.io_write = 1'b1;
        tb_wdata        = d;
        tb_drive        = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.io_ready && n < 8);
        check_val("wr_latency", n, 1);
        bus_if.io_write = 1'b0;
        tb_drive        = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        bus_if.io_addr = a;
        bus_if.io_read = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.io_ready && n < 8);
        check_val("rd_latency", n, 1);
        d = io_data;
        bus_if.io_read = 1'b0;
    endtask

    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (!irq && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n;
        logic [31:0] seq_exp [4];
        logic [3:0]  rdy_pat;

        seq_exp = '{32'd0, 32'd1, 32'd2, 32'd0};
        rdy_pat = 4'b0101;

        rst             = 1'b1;
        bus_if.io_addr  = '0;
        bus_if.io_read  = 1'b0;
        bus_if.io_write = 1'b0;
        tb_wdata        = '0;
        tb_drive        = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", bus_if.io_ready, 0);
        check_val("rst_irq", irq, 0);
        check_val("rst_drive", dut.u_bus.w_drive, 0);
        rst = 1'b0;
        bus_read(A_COUNT, d);  check_val("rst_count", d, 0);
        bus_read(A_CTRL, d);   check_val("rst_ctrl", d, 0);

        // One-shot: match after 6 ticks, EN drops, COUNT holds at COMPARE.
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_CTRL, 32'b101);
        wait_irq(40, n);
        check_val("oneshot_delay", n, 6);
        check_val("oneshot_irq", irq, 1);
        bus_read(A_CTRL, d);   check_val("oneshot_ctrl", d, 32'b100);
        bus_read(A_COUNT, d);  check_val("oneshot_count", d, 5);
        bus_read(A_STATUS, d); check_val("oneshot_status", d, 1);
        bus_write(A_STATUS, 32'd1);
        check_val("oneshot_irq_clr", irq, 0);

        // Autoreload with prescale 3: tick every 4 clk, match every 12 clk.
        bus_write(A_COMPARE, 32'd2);
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'b111);
        wait_irq(60, n);
        check_val("auto_first", n, 12);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_COUNT, d);
            check_val("auto_count_seq", d, seq_exp[i]);
            repeat (2) @(negedge clk);
        end
        bus_write(A_STATUS, 32'd1);
        check_val("auto_irq_clr", irq, 0);
        wait_irq(60, n);
        check_val("auto_period", n, 6);
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STATUS, 32'd1);

        // Held read strobe: ready and data on alternate cycles only.
        bus_write(A_COUNT, 32'h1234);
        @(negedge clk);
        bus_if.io_addr = A_COUNT;
        bus_if.io_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("held_ready", bus_if.io_ready, rdy_pat[i]);
            check_val("held_drive", dut.u_bus.w_drive, rdy_pat[i]);
            if (bus_if.io_ready) check_val("held_data", io_data, 32'h1234);
        end
        bus_if.io_read = 1'b0;
        bus_read(6'd9, d);     check_val("unmapped9", d, 0);
        bus_write(6'd5, 32'hFFFF_FFFF);
        bus_read(6'd5, d);     check_val("unmapped5", d, 0);

        // COUNT write lands on a tick edge: written value wins, then matches.
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COMPARE, 32'h10);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'b101);
        bus_write(A_COUNT, 32'h10);
        bus_read(A_COUNT, d);  check_val("wr_vs_tick_count", d, 32'h10);
        bus_read(A_CTRL, d);   check_val("wr_vs_tick_ctrl", d, 32'b100);
        bus_read(A_STATUS, d); check_val("wr_vs_tick_status", d, 1);
        bus_write(A_STATUS, 32'd1);

        // W1C on the match edge: MATCH must stay set.
        bus_write(A_COMPARE, 32'd1);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'b101);
        bus_write(A_STATUS, 32'd1);
        check_val("w1c_vs_match_irq", irq, 1);
        bus_read(A_STATUS, d); check_val("w1c_vs_match_status", d, 1);
        bus_write(A_STATUS, 32'd1);
        check_val("w1c_clear_irq", irq, 0);

        // All-ones COUNT wraps to 0 without MATCH, then matches at 7.
        bus_write(A_COMPARE, 32'd7);
        bus_write(A_COUNT, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'b101);
        bus_read(A_COUNT, d);  check_val("wrap_count", d, 0);
        bus_read(A_STATUS, d); check_val("wrap_no_match", d, 0);
        wait_irq(40, n);
        check_val("wrap_match_delay", n, 5);
        bus_read(A_COUNT, d);  check_val("wrap_final_count", d, 7);

        // Reset in the middle of an acknowledged read.
        @(negedge clk);
        bus_if.io_addr = A_COUNT;
        bus_if.io_read = 1'b1;
        @(negedge clk);
        check_val("midrst_pre_ready", bus_if.io_ready, 1);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_ready", bus_if.io_ready, 0);
        check_val("midrst_irq", irq, 0);
        check_val("midrst_drive", dut.u_bus.w_drive, 0);
        @(negedge clk);
        rst            = 1'b0;
        bus_if.io_read = 1'b0;
        bus_read(A_COUNT, d);  check_val("midrst_count", d, 0);
        bus_read(A_CTRL, d);   check_val("midrst_ctrl", d, 0);
        bus_read(A_STATUS, d); check_val("midrst_status", d, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
